fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one 8-bit synchronous FIFO (depth 16, ports wr_en/din/full) between several producers. Each producer offers packets over a valid/ready/last handshake. The arbiter grants one producer at a time for a burst and drives the FIFO write port from that producer. It sits directly in front of the FIFO's write port; the FIFO's read side is untouched.

## Interface
- N_REQ, 4, number of producers (2..8)
- DATA_W, 8, data width; matches FIFO din
- MAX_BURST, 16, maximum beats per grant (equal to FIFO depth)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  producer i has a beat on its data slice
- req_data  in  N_REQ*DATA_W  producer i data in bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  beat is the last of producer i's packet
- req_ready  out  N_REQ  beat accepted when valid and ready are both high
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DATA_W  FIFO write data
- grant_id  out  clog2(N_REQ)  current owner; meaningful while busy
- busy  out  1  high in BURST state

## Operation
- States: IDLE and BURST. Registers: state, owner, last_owner, beat_cnt (width clog2(MAX_BURST+1)).
- IDLE: if any req_valid is high, pick the first valid index searching from last_owner+1 upward, wrapping modulo N_REQ. Set owner to that index, clear beat_cnt, and go to BURST. If no req_valid is high, stay in IDLE.
- BURST:
  - req_ready[owner] = !fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[owner] & req_ready[owner]. fifo_din is always req_data of the owner slice.
  - Each accepted beat increments beat_cnt.
  - An accepted beat with req_last high, or the accepted beat that makes beat_cnt equal MAX_BURST, ends the burst. On that beat: last_owner <= owner and state goes to IDLE.
  - If the owner drops valid mid-burst, the grant is held. There is no timeout.
- fifo_full high: no ready, no write. The producer must hold its data. Transfer resumes on the first cycle fifo_full is low.
- Simultaneous end-of-burst and new requests: the next grant is decided in the IDLE cycle that follows. There is no back-to-back grant without IDLE.

## Timing
- Reset values:
  - state=IDLE, owner=0, last_owner=N_REQ-1 (so producer 0 wins first), beat_cnt=0.
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_din=0, grant_id=0, busy=0.
- fifo_din is forced to 0 while in IDLE.
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge k gives ready in cycle k+1, when fifo_full is low.
- Throughput in BURST: 1 beat per clock. Per-packet overhead: 1 IDLE cycle.
- req_ready, fifo_wr_en and fifo_din are combinational from registered state/owner plus fifo_full and req_valid/req_data. There are no combinational paths from req_valid to req_ready.
- Reset asserted mid-burst: all registers clear immediately (asynchronously). The partial packet is abandoned, and the producer restarts it.

## Configuration
- FIFO_ARB_STATS_EN defined: adds the following ports.
  - stat_sel  in  clog2(N_REQ)
  - stat_beats  out  16
- stat_beats is the number of beats accepted from producer stat_sel since reset. One 16-bit counter per producer, saturating at 16'hFFFF, cleared by reset.
- stat_beats is combinational from stat_sel to the counter mux.
- FIFO_ARB_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BURST)
  - default constants ARB_N_REQ=4, ARB_DATA_W=8, ARB_MAX_BURST=16
  - the stat counter width of 16
- One sub-module: rr_picker. It is combinational. Inputs: req vector and last_owner. Outputs: pick index and any_req.

## Test plan
- Single producer: producer 0 sends 8'hAA, 8'hBB, 8'hCC, with last on 8'hCC.
  - fifo_wr_en is high for 3 consecutive cycles with din AA/BB/CC and grant_id=0.
  - busy then drops for 1 cycle (IDLE).
- Fairness: all 4 producers continuously valid with 1-beat packets (data 8'h10+i).
  - FIFO receives 10,11,12,13,10,... in that order.
  - A write occurs every other cycle.
- Backpressure: producer 1 is mid-packet; fifo_full is forced high for 3 cycles.
  - req_ready=0 and fifo_wr_en=0 for those cycles, and the data is not lost.
  - The next beat is written on the first cycle fifo_full is low.
- Burst cap: producer 2 streams 20 beats with no last while producer 3 waits.
  - After 16 writes the grant returns to IDLE, and producer 3 gets the next grant.
  - Producer 2 regains the grant afterward for the remaining 4 beats.
- Reset mid-burst: assert reset during beat 5 of producer 1.
  - All outputs go to 0 immediately.
  - After release with producers 0 and 1 both valid, the grant goes to producer 0.
- Stats (only with FIFO_ARB_STATS_EN): after the fairness test has run for 8 grants, stat_sel=1 reads stat_beats=2. After 70000 accepted beats from producer 0, stat_sel=0 reads 16'hFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_DATA_W    = 8;
  localparam int ARB_MAX_BURST = 16;
  localparam int ARB_STAT_W    = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [$clog2(N_REQ)-1:0] pick,
  output logic                     any_req
);

  localparam int ID_W = $clog2(N_REQ);

  // w_cand[k] is the index checked at priority k (0 = highest).
  logic [ID_W-1:0] w_cand [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand[gi] = ID_W'((int'(last_owner) + gi + 1) % N_REQ);
    end
  endgenerate

  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[w_cand[k]]) pick = w_cand[k];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter driving one FIFO write port from N_REQ packet producers.
// Optional per-producer beat counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = ARB_N_REQ,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(N_REQ)-1:0]  stat_sel,
  output logic [ARB_STAT_W-1:0]     stat_beats
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state, w_state_next;
  logic [ID_W-1:0]  r_owner, w_owner_next;
  logic [ID_W-1:0]  r_last_owner, w_last_owner_next;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
  logic [ID_W-1:0]  w_pick;
  logic             w_any_req, w_busy, w_accept, w_burst_end;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (req_valid),
    .last_owner (r_last_owner),
    .pick       (w_pick),
    .any_req    (w_any_req)
  );

  assign w_busy = (r_state == ARB_BURST);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_busy && (r_owner == ID_W'(gi)) && !fifo_full;
    end
  endgenerate

  assign w_accept    = w_busy && req_valid[r_owner] && !fifo_full;
  // Either the packet ends or this beat would be the MAX_BURST-th of the grant.
  assign w_burst_end = w_accept && (req_last[r_owner] || (r_beat_cnt == LAST_CNT));
  assign fifo_wr_en  = w_accept;
  assign fifo_din    = w_busy ? req_data[int'(r_owner)*DATA_W +: DATA_W] : '0;
  assign grant_id    = r_owner;
  assign busy        = w_busy;

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_beat_cnt_next   = r_beat_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_state_next    = ARB_BURST;
          w_owner_next    = w_pick;
          w_beat_cnt_next = '0;
        end
      end
      ARB_BURST: begin
        if (w_accept) w_beat_cnt_next = r_beat_cnt + 1'b1;
        if (w_burst_end) begin
          w_state_next      = ARB_IDLE;
          w_last_owner_next = r_owner;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= '0;
      r_last_owner <= ID_W'(N_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_beat_cnt   <= w_beat_cnt_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [ARB_STAT_W-1:0] r_stat_cnt [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stat_cnt[gi] <= '0;
        end else if (w_accept && (r_owner == ID_W'(gi)) && (r_stat_cnt[gi] != '1)) begin
          r_stat_cnt[gi] <= r_stat_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stat_beats = r_stat_cnt[stat_sel];
`endif

endmodule
